fb_pixel_writer: RTL and testbench

FB_PIXEL_WRITER -- requirements
Module: fb_pixel_writer

---
 rtl/fb_pixel_writer.sv | 120 ++++++++++++
 tb/tb_fb_pixel_writer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pixel_writer.sv
// Tile framebuffer writer: read-modify-write of single byte pixels into 32-bit
// words, plus a full-screen clear that streams one fill word per cycle.
module fb_pixel_writer #(
  parameter int COLS  = 20,
  parameter int ROWS  = 15,
  parameter int WPR   = 5,
  parameter int WORDS = 75
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        px_valid,
  output logic        px_ready,
  input  logic [4:0]  px_col,
  input  logic [3:0]  px_row,
  input  logic [7:0]  px_color,
  input  logic        clr_valid,
  input  logic [7:0]  clr_color,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [6:0]  mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);
  localparam int AW = 7;
  localparam int NB = 4;
  localparam logic [AW-1:0] LAST   = AW'(WORDS - 1);
  localparam logic [4:0]    COLS_L = COLS[4:0];
  localparam logic [3:0]    ROWS_L = ROWS[3:0];

  typedef enum logic [1:0] {IDLE, RD, WR, CLR} state_t;

  typedef struct packed {
    logic [1:0] lane;
    logic [7:0] color;
  } px_req_t;

  state_t          state, state_nx;
  px_req_t         req_q;
  logic [AW-1:0]   addr_q;
  logic [31:0]     wdata_q;
  logic            done_q, err_q;
  logic            accept, in_range;
  logic [AW-1:0]   px_addr;
  logic [NB-1:0][7:0] merged;

  assign px_ready = (state == IDLE) && !clr_valid;
  assign accept   = px_valid && px_ready;
  assign in_range = (px_col < COLS_L) && (px_row < ROWS_L);
  assign px_addr  = AW'(px_col[4:2]) + AW'(px_row) * AW'(WPR);

  // Lane 0 is the most significant byte, so byte b of the word is lane NB-1-b.
  for (genvar b = 0; b < NB; b++) begin : g_lane
    assign merged[b] = (req_q.lane == 2'(NB - 1 - b)) ? req_q.color
                                                     : mem_rdata[8*b +: 8];
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (clr_valid)              state_nx = CLR;
        else if (accept && in_range) state_nx = RD;
      end
      RD:      state_nx = WR;
      WR:      state_nx = IDLE;
      CLR:     if (addr_q == LAST) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      req_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (clr_valid) begin
            addr_q  <= '0;
            wdata_q <= {NB{clr_color}};
          end else if (accept) begin
            if (in_range) begin
              addr_q      <= px_addr;
              req_q.lane  <= px_col[1:0];
              req_q.color <= px_color;
            end else begin
              // Out-of-range pixel: no memory traffic, just flag and complete.
              err_q  <= 1'b1;
              done_q <= 1'b1;
            end
          end
        end
        RD: wdata_q <= merged;
        WR: done_q  <= 1'b1;
        CLR: begin
          if (addr_q == LAST) done_q <= 1'b1;
          else                addr_q <= addr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Write strobe decodes straight from state so an async reset kills it at once.
  assign mem_we    = (state == WR) || (state == CLR);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state != IDLE);
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_fb_pixel_writer.sv
// Randomized bench for fb_pixel_writer against a word-array framebuffer model.
module tb_fb_pixel_writer;
  logic        CLOCK_50 = 1'b0;
  logic        reset = 1'b1;
  logic        px_valid = 1'b0, clr_valid = 1'b0;
  logic [4:0]  px_col = '0;
  logic [3:0]  px_row = '0;
  logic [7:0]  px_color = '0, clr_color = '0;
  logic        px_ready, busy, done, err, mem_we;
  logic [6:0]  mem_addr;
  logic [31:0] mem_rdata, mem_wdata;

  logic [31:0] ram [0:127];
  logic [31:0] model [0:74];
  logic        bd_we = 1'b0;
  logic [6:0]  bd_addr = '0;
  logic [31:0] bd_data = '0;
  int          wr_cnt = 0;
  bit          bad_addr = 1'b0;
  int          n_vec = 0, n_err = 0;

  fb_pixel_writer dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .px_valid(px_valid), .px_ready(px_ready), .px_col(px_col), .px_row(px_row),
    .px_color(px_color), .clr_valid(clr_valid), .clr_color(clr_color),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  assign mem_rdata = ram[mem_addr];

  always @(posedge CLOCK_50) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
      if (mem_addr > 7'd74) bad_addr <= 1'b1;
    end else if (bd_we) begin
      ram[bd_addr] <= bd_data;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] put_px(input logic [31:0] word, input int c, input logic [7:0] v);
    int sh;
    sh = (3 - c % 4) * 8;
    return (word & ~(32'hFF << sh)) | ({24'd0, v} << sh);
  endfunction

  task automatic bd_write(input int a, input logic [31:0] d);
    @(negedge CLOCK_50);
    bd_we = 1'b1; bd_addr = 7'(a); bd_data = d;
    @(negedge CLOCK_50);
    bd_we = 1'b0;
  endtask

  task automatic ram_compare(input string tag);
    for (int i = 0; i < 75; i++) chk(tag, ram[i], model[i]);
  endtask

  task automatic do_pixel(input logic [4:0] c, input logic [3:0] r, input logic [7:0] v);
    int w0, wi;
    logic ok;
    logic [31:0] exp;
    ok = (c < 20) && (r < 15);
    @(negedge CLOCK_50);
    chk("px_ready_idle", 32'(px_ready), 32'd1);
    px_valid = 1'b1; px_col = c; px_row = r; px_color = v;
    w0 = wr_cnt;
    @(negedge CLOCK_50);
    px_valid = 1'b0;
    if (ok) begin
      wi = c / 4 + r * 5;
      exp = put_px(model[wi], c, v);
      model[wi] = exp;
      chk("rd_we", 32'(mem_we), 32'd0);
      chk("rd_addr", 32'(mem_addr), 32'(wi));
      chk("rd_busy", 32'(busy), 32'd1);
      chk("rd_done", 32'(done), 32'd0);
      @(negedge CLOCK_50);
      chk("wr_we", 32'(mem_we), 32'd1);
      chk("wr_addr", 32'(mem_addr), 32'(wi));
      chk("wr_data", mem_wdata, exp);
      @(negedge CLOCK_50);
      chk("px_done", 32'(done), 32'd1);
      chk("px_ready_again", 32'(px_ready), 32'd1);
      chk("px_ram", ram[wi], exp);
      chk("px_nwrites", 32'(wr_cnt - w0), 32'd1);
    end else begin
      chk("drop_done", 32'(done), 32'd1);
      chk("drop_err", 32'(err), 32'd1);
      chk("drop_we", 32'(mem_we), 32'd0);
      chk("drop_busy", 32'(busy), 32'd0);
      chk("drop_nwrites", 32'(wr_cnt - w0), 32'd0);
    end
  endtask

  initial begin
    int w0, k, c, r;
    logic [31:0] exp;
    logic [31:0] pend_exp;
    int pend_w;

    #1;
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_addr", 32'(mem_addr), 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);

    for (int i = 0; i < 75; i++) begin
      exp = (i == 6) ? 32'h11223344 : $urandom;
      model[i] = exp;
      bd_write(i, exp);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    #1 chk("post_rst_ready", 32'(px_ready), 32'd1);

    do_pixel(5'd6, 4'd1, 8'h3F);
    chk("word6", ram[6], 32'h11223F44);
    do_pixel(5'd19, 4'd14, 8'h0C);
    chk("word74_lane3", 32'(ram[74][7:0]), 32'h0C);
    do_pixel(5'd20, 4'd0, 8'h2A);
    do_pixel(5'd2, 4'd3, 8'h15);
    chk("err_sticky", 32'(err), 32'd1);

    for (int i = 0; i < 40; i++)
      do_pixel(5'($urandom_range(23)), 4'($urandom_range(15)), 8'($urandom));
    ram_compare("ram_after_pixels");

    // Clear wins over a simultaneous pixel request.
    @(negedge CLOCK_50);
    clr_valid = 1'b1; clr_color = 8'h30;
    px_valid = 1'b1; px_col = 5'd3; px_row = 4'd2; px_color = 8'hFF;
    #1 chk("clr_px_ready", 32'(px_ready), 32'd0);
    w0 = wr_cnt;
    @(negedge CLOCK_50);
    clr_valid = 1'b0;
    for (int i = 0; i < 75; i++) begin
      chk("clr_we", 32'(mem_we), 32'd1);
      chk("clr_addr", 32'(mem_addr), 32'(i));
      chk("clr_data", mem_wdata, 32'h30303030);
      chk("clr_ready", 32'(px_ready), 32'd0);
      chk("clr_done", 32'(done), 32'd0);
      model[i] = 32'h30303030;
      if (i < 74) @(negedge CLOCK_50);
    end
    @(negedge CLOCK_50);
    px_valid = 1'b0;
    chk("clr_end_done", 32'(done), 32'd1);
    chk("clr_end_we", 32'(mem_we), 32'd0);
    chk("clr_end_busy", 32'(busy), 32'd0);
    chk("clr_nwrites", 32'(wr_cnt - w0), 32'd75);
    @(negedge CLOCK_50);
    chk("clr_done_once", 32'(done), 32'd0);
    chk("clr_px_dropped", 32'(busy), 32'd0);
    ram_compare("ram_after_clear");

    // Reset in the middle of a clear.
    @(negedge CLOCK_50);
    clr_valid = 1'b1; clr_color = 8'hA5;
    @(negedge CLOCK_50);
    clr_valid = 1'b0;
    k = 0;
    while (mem_addr != 7'd40 && k < 100) begin
      @(negedge CLOCK_50);
      k++;
    end
    chk("abort_reached_40", 32'(mem_addr), 32'd40);
    for (int i = 0; i < 40; i++) model[i] = 32'hA5A5A5A5;
    reset = 1'b1;
    #1;
    chk("abort_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_addr", 32'(mem_addr), 32'd0);
    chk("abort_wdata", mem_wdata, 32'd0);
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
    chk("abort_ready", 32'(px_ready), 32'd1);
    chk("abort_err_cleared", 32'(err), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);
    ram_compare("ram_after_abort");

    // Back-to-back pixels with px_valid held high.
    pend_exp = '0; pend_w = 0;
    @(negedge CLOCK_50);
    px_valid = 1'b1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      chk("b2b_ready", 32'(px_ready), 32'(cyc % 3 == 0));
      chk("b2b_we", 32'(mem_we), 32'(cyc % 3 == 2));
      chk("b2b_done", 32'(done), 32'(cyc % 3 == 0 && cyc > 0));
      if (cyc % 3 == 2) begin
        chk("b2b_addr", 32'(mem_addr), 32'(pend_w));
        chk("b2b_data", mem_wdata, pend_exp);
      end
      if (cyc % 3 == 0) begin
        c = $urandom_range(19);
        r = $urandom_range(14);
        px_col = 5'(c); px_row = 4'(r); px_color = 8'($urandom);
        pend_w = c / 4 + r * 5;
        pend_exp = put_px(model[pend_w], c, px_color);
        model[pend_w] = pend_exp;
      end
      @(negedge CLOCK_50);
    end
    px_valid = 1'b0;
    chk("b2b_last_done", 32'(done), 32'd1);
    ram_compare("ram_after_b2b");
    chk("addr_never_over_74", 32'(bad_addr), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
